// File: rtl/branch_hazard_unit.sv
// Branch hazard unit: tracks EX/MEM/WB destinations in a shadow pipeline and decides
// ID-stage branch-compare forwarding and stalls, with a saturating stall counter.
module branch_hazard_unit #(
  parameter int unsigned CntWidth = 16
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ID_Valid_IN,
  input  logic [5:0]  ID_Opcode_IN,
  input  logic [4:0]  ID_RegisterRS_IN,
  input  logic [4:0]  ID_RegisterRT_IN,
  input  logic [4:0]  ID_WriteReg_IN,
  input  logic        ID_RegWrite_IN,
  input  logic        ID_MemRead_IN,
  output logic [1:0]  ForwardRSbranch_OUT,
  output logic [1:0]  ForwardRTbranch_OUT,
  output logic        Stall_OUT,
  output logic [15:0] StallCycles_OUT
);

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic [4:0] dest;
  } entry_t;

  localparam logic [1:0] FwdRegFile = 2'b00;
  localparam logic [1:0] FwdExMem   = 2'b10;
  localparam logic [1:0] FwdMemWb   = 2'b01;

  entry_t ex_q, ex_d;
  entry_t mem_q, mem_d;
  entry_t wb_q, wb_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  logic uses_rs, uses_rt;
  logic rs_ex, rs_mem, rs_wb;
  logic rt_ex, rt_mem, rt_wb;
  logic stall;

  function automatic logic src_match(entry_t e, logic [4:0] src);
    return e.valid && e.regwrite && (e.dest == src) && (src != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(logic used, logic m_mem, logic mem_load, logic m_wb);
    if (!used) begin
      return FwdRegFile;
    end else if (m_mem && !mem_load) begin
      return FwdExMem;
    end else if (m_wb) begin
      return FwdMemWb;
    end
    return FwdRegFile;
  endfunction

  // Branch classification
  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    if (ID_Valid_IN) begin
      unique case (ID_Opcode_IN)
        6'b000100, 6'b000101: begin
          uses_rs = 1'b1;
          uses_rt = 1'b1;
        end
        6'b000001, 6'b000110, 6'b000111: uses_rs = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    rs_ex  = uses_rs && src_match(ex_q,  ID_RegisterRS_IN);
    rs_mem = uses_rs && src_match(mem_q, ID_RegisterRS_IN);
    rs_wb  = uses_rs && src_match(wb_q,  ID_RegisterRS_IN);
    rt_ex  = uses_rt && src_match(ex_q,  ID_RegisterRT_IN);
    rt_mem = uses_rt && src_match(mem_q, ID_RegisterRT_IN);
    rt_wb  = uses_rt && src_match(wb_q,  ID_RegisterRT_IN);
    // A load still in MEM has no result to forward yet, so it stalls like EX does.
    stall  = !RESET && (rs_ex || rt_ex || (mem_q.memread && (rs_mem || rt_mem)));
  end

  always_comb begin
    Stall_OUT           = stall;
    ForwardRSbranch_OUT = FwdRegFile;
    ForwardRTbranch_OUT = FwdRegFile;
    if (!RESET && !stall) begin
      ForwardRSbranch_OUT = fwd_sel(uses_rs, rs_mem, mem_q.memread, rs_wb);
      ForwardRTbranch_OUT = fwd_sel(uses_rt, rt_mem, mem_q.memread, rt_wb);
    end
    StallCycles_OUT = 16'(cnt_q);
  end

  always_comb begin
    ex_d  = '0;
    mem_d = ex_q;
    wb_d  = mem_q;
    cnt_d = cnt_q;
    if (!stall && ID_Valid_IN) begin
      ex_d.valid    = 1'b1;
      ex_d.regwrite = ID_RegWrite_IN;
      ex_d.memread  = ID_MemRead_IN;
      ex_d.dest     = ID_WriteReg_IN;
    end
    if (stall && (cnt_q != {CntWidth{1'b1}})) begin
      cnt_d = cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Directed bench for branch_hazard_unit; a second instance with a 4-bit counter
// exercises saturation in a short run.
module tb_branch_hazard_unit;

  localparam logic [5:0] OpAlu  = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpBgtz = 6'b000111;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        id_valid;
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_wr;
  logic        id_regw, id_memrd;
  logic [1:0]  fwd_rs, fwd_rt;
  logic        stall;
  logic [15:0] cnt;
  logic [1:0]  sat_fwd_rs, sat_fwd_rt;
  logic        sat_stall;
  logic [15:0] sat_cnt;

  int total = 0;
  int bad   = 0;

  always #5 CLOCK = ~CLOCK;

  branch_hazard_unit dut (
    .CLOCK(CLOCK), .RESET(RESET), .ID_Valid_IN(id_valid), .ID_Opcode_IN(id_op),
    .ID_RegisterRS_IN(id_rs), .ID_RegisterRT_IN(id_rt), .ID_WriteReg_IN(id_wr),
    .ID_RegWrite_IN(id_regw), .ID_MemRead_IN(id_memrd),
    .ForwardRSbranch_OUT(fwd_rs), .ForwardRTbranch_OUT(fwd_rt),
    .Stall_OUT(stall), .StallCycles_OUT(cnt)
  );

  branch_hazard_unit #(.CntWidth(4)) dut_sat (
    .CLOCK(CLOCK), .RESET(RESET), .ID_Valid_IN(id_valid), .ID_Opcode_IN(id_op),
    .ID_RegisterRS_IN(id_rs), .ID_RegisterRT_IN(id_rt), .ID_WriteReg_IN(id_wr),
    .ID_RegWrite_IN(id_regw), .ID_MemRead_IN(id_memrd),
    .ForwardRSbranch_OUT(sat_fwd_rs), .ForwardRTbranch_OUT(sat_fwd_rt),
    .Stall_OUT(sat_stall), .StallCycles_OUT(sat_cnt)
  );

  task automatic cyc();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] wr, input logic rw,
                        input logic mr);
    id_valid = v; id_op = op; id_rs = rs; id_rt = rt;
    id_wr = wr; id_regw = rw; id_memrd = mr;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, OpAlu, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [4:0] wr);
    set_id(1'b1, OpAlu, 5'd0, 5'd0, wr, 1'b1, 1'b0);
  endtask

  task automatic lw(input logic [4:0] wr);
    set_id(1'b1, OpLw, 5'd0, 5'd0, wr, 1'b1, 1'b1);
  endtask

  task automatic br(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    set_id(1'b1, op, rs, rt, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    idle();
    cyc();
    RESET = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    br(OpBeq, 5'd5, 5'd6);
    cyc();
    cyc();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    total++; if (fwd_rs !== 2'b00 || fwd_rt !== 2'b00) begin
      bad++; $display("FAIL reset_fwd: got %b/%b want 00/00", fwd_rs, fwd_rt);
    end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    RESET = 1'b0;
    idle();
  endtask

  task automatic test_alu_fwd();
    do_reset();
    alu(5'd5);
    cyc();
    br(OpBeq, 5'd5, 5'd6);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL alu_stall: got %b want 1", stall); end
    total++; if (fwd_rs !== 2'b00) begin bad++; $display("FAIL alu_fwd_in_stall: got %b want 00", fwd_rs); end
    cyc();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall_end: got %b want 0", stall); end
    total++; if (fwd_rs !== 2'b10 || fwd_rt !== 2'b00) begin
      bad++; $display("FAIL alu_fwd: got %b/%b want 10/00", fwd_rs, fwd_rt);
    end
    total++; if (cnt !== 16'd1) begin bad++; $display("FAIL alu_cnt: got %0d want 1", cnt); end
    cyc();
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    lw(5'd8);
    cyc();
    br(OpBne, 5'd1, 5'd8);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lw_stall1: got %b want 1", stall); end
    cyc();
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lw_stall2: got %b want 1", stall); end
    total++; if (fwd_rt !== 2'b00) begin bad++; $display("FAIL lw_fwd_in_stall: got %b want 00", fwd_rt); end
    cyc();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lw_stall_end: got %b want 0", stall); end
    total++; if (fwd_rt !== 2'b01 || fwd_rs !== 2'b00) begin
      bad++; $display("FAIL lw_fwd: got rs=%b rt=%b want rs=00 rt=01", fwd_rs, fwd_rt);
    end
    total++; if (cnt !== 16'd2) begin bad++; $display("FAIL lw_cnt: got %0d want 2", cnt); end
    cyc();
    idle();
  endtask

  task automatic test_reg0_unused();
    do_reset();
    alu(5'd0);
    cyc();
    idle();
    cyc();
    br(OpBeq, 5'd0, 5'd0);
    total++; if (stall !== 1'b0 || fwd_rs !== 2'b00 || fwd_rt !== 2'b00) begin
      bad++; $display("FAIL reg0: got stall=%b fwd=%b/%b want 0 00/00", stall, fwd_rs, fwd_rt);
    end
    do_reset();
    alu(5'd5);
    cyc();
    idle();
    cyc();
    br(OpBgtz, 5'd1, 5'd5);
    total++; if (stall !== 1'b0 || fwd_rt !== 2'b00) begin
      bad++; $display("FAIL unused_rt: got stall=%b rt=%b want 0 00", stall, fwd_rt);
    end
    br(OpBeq, 5'd1, 5'd5);
    total++; if (fwd_rt !== 2'b10 || fwd_rs !== 2'b00) begin
      bad++; $display("FAIL used_rt: got rs=%b rt=%b want rs=00 rt=10", fwd_rs, fwd_rt);
    end
    idle();
  endtask

  task automatic test_priority();
    do_reset();
    alu(5'd3);
    cyc();
    alu(5'd3);
    cyc();
    idle();
    cyc();
    br(OpBeq, 5'd3, 5'd7);
    total++; if (stall !== 1'b0 || fwd_rs !== 2'b10) begin
      bad++; $display("FAIL prio_mem: got stall=%b rs=%b want 0 10", stall, fwd_rs);
    end
    cyc();
    br(OpBeq, 5'd3, 5'd7);
    total++; if (stall !== 1'b0 || fwd_rs !== 2'b01) begin
      bad++; $display("FAIL prio_wb: got stall=%b rs=%b want 0 01", stall, fwd_rs);
    end
    idle();
  endtask

  task automatic test_non_branch();
    do_reset();
    lw(5'd8);
    cyc();
    set_id(1'b1, OpAlu, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL nonbranch: got %b want 0", stall); end
    set_id(1'b0, OpBeq, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL invalid_branch: got %b want 0", stall); end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    alu(5'd5);
    cyc();
    alu(5'd6);
    cyc();
    br(OpBeq, 5'd5, 5'd6);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_stall: got %b want 1", stall); end
    cyc();
    total++; if (stall !== 1'b0 || fwd_rs !== 2'b01 || fwd_rt !== 2'b10) begin
      bad++; $display("FAIL b2b_fwd: got stall=%b fwd=%b/%b want 0 01/10", stall, fwd_rs, fwd_rt);
    end
    total++; if (cnt !== 16'd1) begin bad++; $display("FAIL b2b_cnt: got %0d want 1", cnt); end
    cyc();
    idle();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    lw(5'd8);
    cyc();
    br(OpBne, 5'd1, 5'd8);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rms_pre: got %b want 1", stall); end
    RESET = 1'b1;
    #1;
    total++; if (stall !== 1'b0 || fwd_rt !== 2'b00) begin
      bad++; $display("FAIL rms_forced: got stall=%b rt=%b want 0 00", stall, fwd_rt);
    end
    cyc();
    RESET = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rms_after: got %b want 0", stall); end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL rms_cnt: got %0d want 0", cnt); end
    cyc();
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL rms_cnt_hold: got %0d want 0", cnt); end
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      lw(5'd8);
      cyc();
      br(OpBne, 5'd8, 5'd2);
      cyc();
      cyc();
      if (i == 7) begin
        total++; if (sat_cnt !== 16'd14) begin bad++; $display("FAIL sat_pre: got %0d want 14", sat_cnt); end
      end
    end
    total++; if (sat_cnt !== 16'h000F) begin bad++; $display("FAIL sat_hold: got %0h want f", sat_cnt); end
    total++; if (cnt !== 16'd20) begin bad++; $display("FAIL sat_wide_cnt: got %0d want 20", cnt); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_reg0_unused();
    test_priority();
    test_non_branch();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_hazard_unit.md
BRANCH_HAZARD_UNIT -- requirements
Module: branch_hazard_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset named as the codebase does: CLOCK and RESET.
REQ-002 CLOCK  in  1  rising-edge clock for all state.
REQ-003 RESET  in  1  synchronous, active-high; sampled only on a CLOCK rising edge.
REQ-004 ID_Valid_IN  in  1  ID stage holds a real instruction.
REQ-005 ID_Opcode_IN  in  6  opcode of the ID instruction.
REQ-006 ID_RegisterRS_IN  in  5  RS field of the ID instruction.
REQ-007 ID_RegisterRT_IN  in  5  RT field of the ID instruction.
REQ-008 ID_WriteReg_IN  in  5  destination register of the ID instruction.
REQ-009 ID_RegWrite_IN  in  1  ID instruction writes a register.
REQ-010 ID_MemRead_IN  in  1  ID instruction is a load.
REQ-011 ForwardRSbranch_OUT  out  2  RS source select for branch compare: 00 = register file, 10 = EX/MEM ALU result, 01 = MEM/WB result.
REQ-012 ForwardRTbranch_OUT  out  2  RT source select, same encoding.
REQ-013 Stall_OUT  out  1  hold PC and IF/ID; insert a bubble into EX.
REQ-014 StallCycles_OUT  out  16  saturating count of stall cycles.

Function
REQ-015 The block SHALL keep a 3-entry shadow pipeline (EX, MEM, WB). Each entry SHALL hold {valid, regwrite, memread, dest[4:0]}.
REQ-016 On each edge with RESET low, the shadow pipeline SHALL advance as follows: WB<=MEM; MEM<=EX; EX<=ID fields gated by ID_Valid_IN when Stall_OUT=0; EX<=invalid bubble when Stall_OUT=1.
REQ-017 The block SHALL classify the ID instruction as follows:
- uses RS and RT: opcode 6'b000100 or 6'b000101.
- uses RS only: opcode 6'b000001, 6'b000110 or 6'b000111.
- not a branch: any other opcode, or ID_Valid_IN=0.
REQ-018 A source register SHALL match a shadow entry only when all of the following hold: entry.valid=1, entry.regwrite=1, entry.dest equals the source, and the source is non-zero. Register 0 SHALL never match.
REQ-019 Stall_OUT SHALL be 1 when any used branch source matches either of:
- the EX entry (ALU or load);
- the MEM entry with memread=1.
Otherwise Stall_OUT SHALL be 0.
REQ-020 A load in EX feeding a branch SHALL therefore produce exactly 2 consecutive stall cycles. An ALU op in EX feeding a branch SHALL produce exactly 1 stall cycle.
REQ-021 For each used source with no stall, the forward select SHALL be:
- 10 if it matches the MEM entry with memread=0;
- else 01 if it matches the WB entry;
- else 00.
REQ-022 When the MEM and WB entries both match, the MEM entry SHALL take priority.
REQ-023 The forward select for an unused source, and both selects while Stall_OUT=1, SHALL be 00.
REQ-024 Forward selects and Stall_OUT SHALL be combinational from current shadow state and ID inputs, with zero-cycle latency. Only the shadow pipeline and StallCycles_OUT SHALL be registered.
REQ-025 StallCycles_OUT SHALL increment by 1 on each edge where Stall_OUT=1, and SHALL saturate at 16'hFFFF without wrapping.
REQ-026 A non-branch ID instruction SHALL never cause a stall, even when its sources match in-flight destinations.

Reset
REQ-027 An edge with RESET=1 SHALL invalidate all shadow entries and clear StallCycles_OUT to 0. This overrides any concurrent advance or increment.
REQ-028 While RESET=1, the outputs SHALL be forced to:
- ForwardRSbranch_OUT=00;
- ForwardRTbranch_OUT=00;
- Stall_OUT=0.
REQ-029 If RESET is asserted mid-stall, the stall SHALL end. On the first cycle after RESET deasserts, Stall_OUT SHALL be 0 regardless of ID inputs.

Verification
REQ-030 ALU forwarding:
- Stimulus: ADD writing $5 enters EX; next cycle BEQ with rs=$5, rt=$6 in ID.
- Required response: Stall_OUT=1 for one cycle, then ForwardRSbranch_OUT=10 and ForwardRTbranch_OUT=00; StallCycles_OUT=1.
REQ-031 Load-use into branch:
- Stimulus: LW writing $8 enters EX; next cycle BNE with rs=$1, rt=$8.
- Required response: Stall_OUT=1 for 2 cycles, then ForwardRTbranch_OUT=01 and ForwardRSbranch_OUT=00.
REQ-032 Register 0 and unused RT:
- Stimulus 1: ADD writing $0 in MEM; BEQ rs=$0.
- Required response 1: select 00, no stall.
- Stimulus 2: BGTZ with rt field=$5 while $5 is in MEM.
- Required response 2: ForwardRTbranch_OUT=00.
REQ-033 Priority:
- Stimulus: $3 written by the MEM entry and by the WB entry; BEQ rs=$3.
- Required response: ForwardRSbranch_OUT=10.
REQ-034 Reset mid-stall:
- Stimulus: LW $8 in EX, BNE rt=$8 in ID; assert RESET for 1 cycle during the first stall cycle.
- Required response: StallCycles_OUT=0; Stall_OUT=0 after release.
REQ-035 Saturation:
- Stimulus: hold a stalling condition, with the counter preloaded via repeated stalls, for 65 540 cycles.
- Required response: StallCycles_OUT holds at 16'hFFFF.
